// File: rtl/shim_integ_pkg.sv
// Shared types and constants for the shim integrator sequencer.
// Also holds the fault-code priority used when several integrator flags rise together.
package shim_integ_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST        = 3'd1,
    ST_START      = 3'd2,
    ST_WAIT_SETUP = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  localparam logic [2:0] FAULT_NONE          = 3'd0;
  localparam logic [2:0] FAULT_OVER_THRESH   = 3'd1;
  localparam logic [2:0] FAULT_OVERFLOW      = 3'd2;
  localparam logic [2:0] FAULT_UNDERFLOW     = 3'd3;
  localparam logic [2:0] FAULT_SETUP_TIMEOUT = 3'd4;
  localparam logic [2:0] FAULT_BAD_CFG       = 3'd5;

  localparam int unsigned MIN_WINDOW_DEF    = 2048;
  localparam int unsigned RST_HOLD_DEF      = 4;
  localparam int unsigned SETUP_TIMEOUT_DEF = 1048576;

  // FIFO errors outrank the threshold trip: they mean the integrated value itself is suspect.
  function automatic logic [2:0] flag_fault_code(input logic ovf, input logic unf,
                                                 input logic ot);
    if (ovf)     return FAULT_OVERFLOW;
    else if (unf) return FAULT_UNDERFLOW;
    else if (ot)  return FAULT_OVER_THRESH;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/shim_integrator_sequencer_if.sv
// Sequencer <-> threshold integrator control bundle.
// master = sequencer side, slave = integrator side.
interface shim_integrator_sequencer_if;
  logic        integ_resetn;
  logic        integ_enable;
  logic [31:0] integ_window;
  logic [14:0] integ_threshold;
  logic        setup_done;
  logic        over_thresh;
  logic        err_overflow;
  logic        err_underflow;

  modport master (
    output integ_resetn, integ_enable, integ_window, integ_threshold,
    input  setup_done, over_thresh, err_overflow, err_underflow
  );

  modport slave (
    input  integ_resetn, integ_enable, integ_window, integ_threshold,
    output setup_done, over_thresh, err_overflow, err_underflow
  );
endinterface

// File: rtl/shim_down_counter.sv
// Loadable down-counter that saturates at zero; zero_o is the terminal-count flag.
// Load takes priority over decrement.
module shim_down_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = value_i;
    else if (en_i && (count_q != '0))
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/shim_integrator_sequencer.sv
// Control-plane sequencer for the shim threshold integrator: arm/reset/enable sequencing,
// setup supervision and sticky fault latching with a held shutdown request.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | integrator held in reset, waiting for arm
// RST         | integ_resetn low for the hold count after an accepted arm
// START       | one cycle out of reset with enable still low
// WAIT_SETUP  | enabled, waiting for setup_done against the timeout
// RUN         | set up; monitoring over_thresh / FIFO error flags
// FAULT       | shutdown_req held, fault_code sticky until fault_clear
module shim_integrator_sequencer
  import shim_integ_pkg::*;
#(
  parameter int unsigned MIN_WINDOW      = MIN_WINDOW_DEF,
  parameter int unsigned RST_HOLD_CYCLES = RST_HOLD_DEF,
  parameter int unsigned SETUP_TIMEOUT   = SETUP_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   cfg_window_i,
  input  logic [14:0]                   cfg_threshold_i,
  input  logic                          arm_i,
  input  logic                          disarm_i,
  input  logic                          fault_clear_i,
  shim_integrator_sequencer_if.master   integ,
  output logic                          running_o,
  output logic                          shutdown_req_o,
  output logic [2:0]                    fault_code_o,
  output logic [2:0]                    state_dbg_o
);

  // Counters are loaded with N-1 and the FSM moves on at terminal count, giving exactly N cycles.
  localparam int unsigned HOLD_EFF  = (RST_HOLD_CYCLES == 0) ? 1 : RST_HOLD_CYCLES;
  localparam int unsigned TO_EFF    = (SETUP_TIMEOUT == 0) ? 1 : SETUP_TIMEOUT;
  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_EFF - 1);
  localparam logic [31:0] TO_LOAD   = 32'(TO_EFF - 1);

  state_e      state_q;
  logic        integ_resetn_q;
  logic        integ_enable_q;
  logic [31:0] integ_window_q;
  logic [14:0] integ_threshold_q;
  logic        running_q;
  logic        shutdown_req_q;
  logic [2:0]  fault_code_q;

  logic        cfg_ok;
  logic [2:0]  flag_code;
  logic        flag_any;
  logic        hold_load, hold_en, hold_zero;
  logic        to_load, to_en, to_zero;

  assign cfg_ok    = (cfg_window_i >= MIN_WINDOW);
  assign flag_code = flag_fault_code(integ.err_overflow, integ.err_underflow, integ.over_thresh);
  assign flag_any  = (flag_code != FAULT_NONE);

  assign hold_load = (state_q == ST_IDLE) && arm_i && cfg_ok;
  assign hold_en   = (state_q == ST_RST);
  assign to_load   = (state_q == ST_START);
  assign to_en     = (state_q == ST_WAIT_SETUP);

  shim_down_counter #(.W(32)) u_hold_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (hold_load),
    .en_i    (hold_en),
    .value_i (HOLD_LOAD),
    .zero_o  (hold_zero)
  );

  shim_down_counter #(.W(32)) u_timeout_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (to_load),
    .en_i    (to_en),
    .value_i (TO_LOAD),
    .zero_o  (to_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q           <= ST_IDLE;
      integ_resetn_q    <= 1'b0;
      integ_enable_q    <= 1'b0;
      integ_window_q    <= '0;
      integ_threshold_q <= '0;
      running_q         <= 1'b0;
      shutdown_req_q    <= 1'b0;
      fault_code_q      <= FAULT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            if (!cfg_ok) begin
              state_q        <= ST_FAULT;
              fault_code_q   <= FAULT_BAD_CFG;
              shutdown_req_q <= 1'b1;
            end else begin
              state_q           <= ST_RST;
              integ_window_q    <= cfg_window_i;
              integ_threshold_q <= cfg_threshold_i;
            end
          end
        end
        ST_RST: begin
          if (disarm_i) begin
            state_q <= ST_IDLE;
          end else if (hold_zero) begin
            state_q        <= ST_START;
            integ_resetn_q <= 1'b1;
          end
        end
        ST_START: begin
          if (disarm_i) begin
            state_q        <= ST_IDLE;
            integ_resetn_q <= 1'b0;
          end else begin
            state_q        <= ST_WAIT_SETUP;
            integ_enable_q <= 1'b1;
          end
        end
        ST_WAIT_SETUP: begin
          // A timeout beats a disarm in the same cycle; setup_done beats the timeout.
          if (!integ.setup_done && to_zero) begin
            state_q        <= ST_FAULT;
            fault_code_q   <= FAULT_SETUP_TIMEOUT;
            shutdown_req_q <= 1'b1;
          end else if (disarm_i) begin
            state_q        <= ST_IDLE;
            integ_enable_q <= 1'b0;
            integ_resetn_q <= 1'b0;
          end else if (integ.setup_done) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flag_any) begin
            state_q        <= ST_FAULT;
            fault_code_q   <= flag_code;
            shutdown_req_q <= 1'b1;
            running_q      <= 1'b0;
          end else if (disarm_i) begin
            state_q        <= ST_IDLE;
            integ_enable_q <= 1'b0;
            integ_resetn_q <= 1'b0;
            running_q      <= 1'b0;
          end
        end
        ST_FAULT: begin
          // Enable is left as-is so the integrator keeps its latched flags for readback.
          if (fault_clear_i) begin
            state_q        <= ST_IDLE;
            shutdown_req_q <= 1'b0;
            fault_code_q   <= FAULT_NONE;
            integ_enable_q <= 1'b0;
            integ_resetn_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          integ_enable_q <= 1'b0;
          integ_resetn_q <= 1'b0;
          running_q      <= 1'b0;
        end
      endcase
    end
  end

  assign integ.integ_resetn    = integ_resetn_q;
  assign integ.integ_enable    = integ_enable_q;
  assign integ.integ_window    = integ_window_q;
  assign integ.integ_threshold = integ_threshold_q;
  assign running_o             = running_q;
  assign shutdown_req_o        = shutdown_req_q;
  assign fault_code_o          = fault_code_q;
  assign state_dbg_o           = state_q;

endmodule
